// File: rtl/div_pkg.sv
// ============================================================================
// Module  : div_pkg
// Brief   : Shared types and sizing for the sequential 32/16 divider.
// Revision: 1.0
// ============================================================================
`default_nettype none

package div_pkg;

    localparam int DEFAULT_WIDTH = 16;

    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

    localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rb_sub.sv
// ============================================================================
// Module  : rb_sub
// Brief   : W-bit ripple-borrow subtractor, a - b, from full-adder cells.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rb_sub #(
    parameter int W = 17
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] diff_o,
    output logic         borrow_o
);

    // a + ~b + 1; a missing carry-out means a < b
    logic [W:0]   w_carry;
    logic [W-1:0] w_nb;

    assign w_carry[0] = 1'b1;
    assign w_nb       = ~b_i;

    generate
        for (genvar i = 0; i < W; i++) begin : g_cell
            assign diff_o[i]    = a_i[i] ^ w_nb[i] ^ w_carry[i];
            assign w_carry[i+1] = (a_i[i] & w_nb[i]) | (w_carry[i] & (a_i[i] ^ w_nb[i]));
        end
    endgenerate

    assign borrow_o = ~w_carry[W];

endmodule

`default_nettype wire

// File: rtl/seq_div_32by16.sv
// ============================================================================
// Module  : seq_div_32by16
// Brief   : Radix-2 restoring divider, 2W-bit dividend by W-bit divisor.
//           Optional macro DIV_ERR_CHECK_EN adds overflow/divide-by-zero flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_div_32by16
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               err
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;

    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_diff;
    logic             w_borrow;
    logic             w_unused_diff_msb;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;

    assign w_trial = {rem_q, quo_q[WIDTH-1]};

    rb_sub #(
        .W (WIDTH + 1)
    ) u_sub (
        .a_i      (w_trial),
        .b_i      ({1'b0, dvs_q}),
        .diff_o   (w_diff),
        .borrow_o (w_borrow)
    );

    // A successful subtract leaves a result below the divisor, so its MSB is dropped
    assign w_unused_diff_msb = w_diff[WIDTH];
    assign rem_d = w_borrow ? w_trial[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign quo_d = {quo_q[WIDTH-2:0], ~w_borrow};

`ifdef DIV_ERR_CHECK_EN
    logic err_q;
    logic w_ovf;
    assign w_ovf = (dividend[2*WIDTH-1:WIDTH] >= divisor);
    assign err   = err_q;
`else
    assign err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
`ifdef DIV_ERR_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
`ifdef DIV_ERR_CHECK_EN
                        if (w_ovf) begin
                            state_q     <= DONE;
                            done_q      <= 1'b1;
                            err_q       <= 1'b1;
                            quotient_q  <= '1;
                            remainder_q <= '0;
                        end else
`endif
                        begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                            rem_q   <= dividend[2*WIDTH-1:WIDTH];
                            quo_q   <= dividend[WIDTH-1:0];
                            dvs_q   <= divisor;
                            cnt_q   <= '0;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == C_LAST) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        quotient_q  <= quo_d;
                        remainder_q <= rem_d;
`ifdef DIV_ERR_CHECK_EN
                        err_q       <= 1'b0;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule

`default_nettype wire
